// File: rtl/axi_llc_burst_merger.sv
`default_nettype none
// ============================================================================
// Module      : axi_llc_burst_merger
// Description : Rebuilds AXI B/R responses from per-cache-line LLC completions.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_llc_burst_merger #(
    parameter logic Write     = 1'b1,
    parameter int   IdWidth   = 6,
    parameter int   DataWidth = 64,
    parameter int   CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [IdWidth-1:0]   in_id_i,
    input  logic [1:0]           in_resp_i,
    input  logic [DataWidth-1:0] in_data_i,
    input  logic                 in_desc_last_i,
    input  logic                 in_burst_last_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [IdWidth-1:0]   out_id_o,
    output logic [1:0]           out_resp_o,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_last_o,
    output logic                 err_o,
    output logic [CntWidth-1:0]  bursts_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    // Severity order DECERR > SLVERR > OKAY > EXOKAY, so EXOKAY only wins alone.
    function automatic logic [1:0] resp_rank(input logic [1:0] r);
        case (r)
            2'b11:   resp_rank = 2'd3;
            2'b10:   resp_rank = 2'd2;
            2'b00:   resp_rank = 2'd1;
            default: resp_rank = 2'd0;
        endcase
    endfunction

    logic [0:0]           state_q, state_d;
    logic [IdWidth-1:0]   acc_id_q, acc_id_d;
    logic [1:0]           acc_resp_q, acc_resp_d;
    logic                 in_burst_q, in_burst_d;
    logic [IdWidth-1:0]   hold_id_q, hold_id_d;
    logic                 out_valid_q;
    logic [IdWidth-1:0]   out_id_q;
    logic [1:0]           out_resp_q;
    logic [DataWidth-1:0] out_data_q;
    logic                 out_last_q;
    logic                 err_q;
    logic [CntWidth-1:0]  bursts_q;

    logic                 w_can_load;
    logic                 w_emit;
    logic                 w_accept;
    logic                 w_load;
    logic                 w_err_set;
    logic [1:0]           w_merged;
    logic [IdWidth-1:0]   w_ld_id;
    logic [1:0]           w_ld_resp;
    logic [DataWidth-1:0] w_ld_data;
    logic                 w_ld_last;

    always_comb begin
        w_can_load = !out_valid_q || out_ready_i;
        w_emit     = Write ? in_burst_last_i : 1'b1;
        // Non-emitting write completions never touch the output register.
        in_ready_o = w_can_load || !w_emit;
        w_accept   = in_valid_i && in_ready_o;

        state_d    = state_q;
        acc_id_d   = acc_id_q;
        acc_resp_d = acc_resp_q;
        in_burst_d = in_burst_q;
        hold_id_d  = hold_id_q;
        w_load     = 1'b0;
        w_err_set  = 1'b0;
        w_merged   = (resp_rank(acc_resp_q) >= resp_rank(in_resp_i)) ? acc_resp_q : in_resp_i;
        w_ld_id    = in_id_i;
        w_ld_resp  = in_resp_i;
        w_ld_data  = Write ? '0 : in_data_i;
        w_ld_last  = Write ? 1'b1 : (in_desc_last_i && in_burst_last_i);

        if (Write) begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (in_burst_last_i) begin
                            w_load = 1'b1;
                        end else begin
                            acc_id_d   = in_id_i;
                            acc_resp_d = in_resp_i;
                            state_d    = ST_ACCUM;
                        end
                    end
                end
                default: begin
                    if (w_accept) begin
                        w_err_set  = (in_id_i != acc_id_q);
                        acc_resp_d = w_merged;
                        if (in_burst_last_i) begin
                            w_load    = 1'b1;
                            w_ld_id   = acc_id_q;
                            w_ld_resp = w_merged;
                            state_d   = ST_IDLE;
                        end
                    end
                end
            endcase
        end else if (w_accept) begin
            w_load     = 1'b1;
            w_err_set  = in_burst_q && (in_id_i != hold_id_q);
            hold_id_d  = in_burst_q ? hold_id_q : in_id_i;
            in_burst_d = !(in_desc_last_i && in_burst_last_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            acc_id_q    <= '0;
            acc_resp_q  <= '0;
            in_burst_q  <= 1'b0;
            hold_id_q   <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_resp_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            bursts_q    <= '0;
        end else begin
            state_q    <= state_d;
            acc_id_q   <= acc_id_d;
            acc_resp_q <= acc_resp_d;
            in_burst_q <= in_burst_d;
            hold_id_q  <= hold_id_d;
            if (w_err_set) begin
                err_q <= 1'b1;
            end
            if (out_valid_q && out_ready_i && out_last_q) begin
                bursts_q <= bursts_q + 1'b1;
            end
            if (w_load) begin
                out_valid_q <= 1'b1;
                out_id_q    <= w_ld_id;
                out_resp_q  <= w_ld_resp;
                out_data_q  <= w_ld_data;
                out_last_q  <= w_ld_last;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_id_o    = out_id_q;
    assign out_resp_o  = out_resp_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign err_o       = err_q;
    assign bursts_o    = bursts_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_llc_burst_merger.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_llc_burst_merger
// Description : Scoreboard bench for write (B-merge) and read (R-forward) modes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_llc_burst_merger;

    logic        clk;
    logic        r_rst;
    logic        r_vw, r_vr;
    logic [5:0]  r_id;
    logic [1:0]  r_resp;
    logic [63:0] r_data;
    logic        r_dl, r_bl;
    logic        r_ordy;

    logic        w_rdy_w, w_ov_w, w_olast_w, w_err_w;
    logic [5:0]  w_oid_w;
    logic [1:0]  w_oresp_w;
    logic [63:0] w_odata_w;
    logic [15:0] w_bursts_w;

    logic        w_rdy_r, w_ov_r, w_olast_r, w_err_r;
    logic [5:0]  w_oid_r;
    logic [1:0]  w_oresp_r;
    logic [63:0] w_odata_r;
    logic [15:0] w_bursts_r;

    int n_total = 0;
    int n_bad   = 0;

    logic [72:0] q_w[$];
    logic [72:0] q_r[$];
    logic [72:0] e_w, e_r;

    axi_llc_burst_merger #(.Write(1'b1), .IdWidth(6), .DataWidth(64), .CntWidth(16)) u_dut_w (
        .clk_i(clk), .rst_i(r_rst),
        .in_valid_i(r_vw), .in_ready_o(w_rdy_w), .in_id_i(r_id), .in_resp_i(r_resp),
        .in_data_i(r_data), .in_desc_last_i(r_dl), .in_burst_last_i(r_bl),
        .out_valid_o(w_ov_w), .out_ready_i(r_ordy), .out_id_o(w_oid_w), .out_resp_o(w_oresp_w),
        .out_data_o(w_odata_w), .out_last_o(w_olast_w), .err_o(w_err_w), .bursts_o(w_bursts_w)
    );

    axi_llc_burst_merger #(.Write(1'b0), .IdWidth(6), .DataWidth(64), .CntWidth(16)) u_dut_r (
        .clk_i(clk), .rst_i(r_rst),
        .in_valid_i(r_vr), .in_ready_o(w_rdy_r), .in_id_i(r_id), .in_resp_i(r_resp),
        .in_data_i(r_data), .in_desc_last_i(r_dl), .in_burst_last_i(r_bl),
        .out_valid_o(w_ov_r), .out_ready_i(r_ordy), .out_id_o(w_oid_r), .out_resp_o(w_oresp_r),
        .out_data_o(w_odata_r), .out_last_o(w_olast_r), .err_o(w_err_r), .bursts_o(w_bursts_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Handshakes complete on the posedge after the negedge where ready is seen.
    always @(negedge clk) begin
        if (!r_rst && w_ov_w && r_ordy) begin
            if (q_w.size() == 0) begin
                check("w_unexpected_out", 1, 0);
            end else begin
                e_w = q_w.pop_front();
                check("w_resp", {w_olast_w, w_oid_w, w_oresp_w, w_odata_w}, e_w);
            end
        end
        if (!r_rst && w_ov_r && r_ordy) begin
            if (q_r.size() == 0) begin
                check("r_unexpected_out", 1, 0);
            end else begin
                e_r = q_r.pop_front();
                check("r_beat", {w_olast_r, w_oid_r, w_oresp_r, w_odata_r}, e_r);
            end
        end
    end

    task automatic do_reset();
        r_rst = 1'b1;
        @(posedge clk);
        #1;
        r_rst = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic rd, input logic [5:0] a_id, input logic [1:0] a_resp,
                        input logic [63:0] a_data, input logic a_dl, input logic a_bl);
        logic acc;
        acc    = 1'b0;
        r_vw   = !rd;
        r_vr   = rd;
        r_id   = a_id;
        r_resp = a_resp;
        r_data = a_data;
        r_dl   = a_dl;
        r_bl   = a_bl;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = rd ? w_rdy_r : w_rdy_w;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 0, 1);
        r_vw = 1'b0;
        r_vr = 1'b0;
    endtask

    initial begin
        logic [63:0] d;
        r_rst = 1'b0; r_vw = 1'b0; r_vr = 1'b0; r_id = '0; r_resp = '0;
        r_data = '0; r_dl = 1'b0; r_bl = 1'b0; r_ordy = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        check("rst_valid_w", w_ov_w, 0);
        check("rst_fields_w", {w_oid_w, w_oresp_w, w_odata_w, w_olast_w}, 0);
        check("rst_err_bursts_w", {w_err_w, w_bursts_w}, 0);
        check("rst_valid_r", w_ov_r, 0);
        check("rst_fields_r", {w_oid_r, w_oresp_r, w_odata_r, w_olast_r}, 0);
        check("rst_err_bursts_r", {w_err_r, w_bursts_r}, 0);

        // Write, three descriptors
        send(0, 6'd5, 2'b00, 64'hDEAD, 1'b1, 1'b0);
        check("t1_noemit_a", w_ov_w, 0);
        send(0, 6'd5, 2'b00, 64'hBEEF, 1'b1, 1'b0);
        check("t1_noemit_b", w_ov_w, 0);
        q_w.push_back({1'b1, 6'd5, 2'b10, 64'd0});
        send(0, 6'd5, 2'b10, 64'hCAFE, 1'b1, 1'b1);
        check("t1_latency", w_ov_w, 1);
        tick(1);
        check("t1_bursts", w_bursts_w, 1);
        check("t1_drained", w_ov_w, 0);
        check("t1_err", w_err_w, 0);

        // EXOKAY merging
        do_reset();
        q_w.push_back({1'b1, 6'd8, 2'b01, 64'd0});
        send(0, 6'd8, 2'b01, 64'h1, 1'b0, 1'b0);
        send(0, 6'd8, 2'b01, 64'h2, 1'b0, 1'b1);
        q_w.push_back({1'b1, 6'd8, 2'b00, 64'd0});
        send(0, 6'd8, 2'b01, 64'h3, 1'b0, 1'b0);
        send(0, 6'd8, 2'b00, 64'h4, 1'b0, 1'b1);
        tick(2);
        check("t2_bursts", w_bursts_w, 2);
        check("t2_q_empty", q_w.size(), 0);

        // Read, two lines of four beats
        do_reset();
        for (int dsc = 0; dsc < 2; dsc++) begin
            for (int b = 0; b < 4; b++) begin
                d = {$urandom(), $urandom()};
                q_r.push_back({(dsc == 1 && b == 3), 6'd2, 2'(b), d});
                send(1, 6'd2, 2'(b), d, (b == 3), (dsc == 1));
            end
        end
        tick(2);
        check("t3_bursts", w_bursts_r, 1);
        check("t3_err", w_err_r, 0);
        check("t3_q_empty", q_r.size(), 0);
        check("t3_w_idle", w_ov_w, 0);

        // Back-pressure
        do_reset();
        r_ordy = 1'b0;
        q_w.push_back({1'b1, 6'd4, 2'b00, 64'd0});
        send(0, 6'd4, 2'b00, 64'h0, 1'b0, 1'b1);
        check("t4_loaded", w_ov_w, 1);
        r_vw = 1'b1; r_id = 6'd6; r_resp = 2'b10; r_data = 64'h77; r_bl = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_ready_low", w_rdy_w, 0);
            check("t4_hold", {w_ov_w, w_oid_w, w_oresp_w, w_olast_w}, {1'b1, 6'd4, 2'b00, 1'b1});
            @(posedge clk);
            #1;
        end
        r_ordy = 1'b1;
        q_w.push_back({1'b1, 6'd6, 2'b10, 64'd0});
        @(negedge clk);
        check("t4_ready_high", w_rdy_w, 1);
        @(posedge clk);
        #1;
        r_vw = 1'b0;
        check("t4_no_bubble", {w_ov_w, w_oid_w, w_oresp_w}, {1'b1, 6'd6, 2'b10});
        tick(1);
        check("t4_drained", w_ov_w, 0);
        check("t4_bursts", w_bursts_w, 2);

        // ID change mid-burst
        do_reset();
        send(0, 6'd1, 2'b00, 64'h0, 1'b0, 1'b0);
        check("t5_err_before", w_err_w, 0);
        q_w.push_back({1'b1, 6'd1, 2'b10, 64'd0});
        send(0, 6'd3, 2'b10, 64'h0, 1'b0, 1'b1);
        check("t5_err_rise", w_err_w, 1);
        tick(3);
        check("t5_err_hold", w_err_w, 1);
        check("t5_q_empty", q_w.size(), 0);

        // Reset mid-burst
        do_reset();
        send(0, 6'd9, 2'b11, 64'h0, 1'b0, 1'b0);
        do_reset();
        check("t6_after_rst", {w_ov_w, w_err_w, w_bursts_w}, 0);
        q_w.push_back({1'b1, 6'd7, 2'b00, 64'd0});
        send(0, 6'd7, 2'b00, 64'h0, 1'b0, 1'b1);
        tick(2);
        check("t6_bursts", w_bursts_w, 1);
        check("t6_q_empty", q_w.size(), 0);
        check("t6_err", w_err_w, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
